// File: rtl/uart_cmd_pkg.sv
// Shared state encoding and ASCII constants for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWAddr,
    StWHi,
    StWLo,
    StWCr,
    StRAddr,
    StRCr,
    StRWait,
    StSkip
  } state_t;

  localparam logic [7:0] AsciiCr  = 8'h0D;
  localparam logic [7:0] AsciiLf  = 8'h0A;
  localparam logic [7:0] AsciiWUp = 8'h57;
  localparam logic [7:0] AsciiWLo = 8'h77;
  localparam logic [7:0] AsciiRUp = 8'h52;
  localparam logic [7:0] AsciiRLo = 8'h72;
  localparam logic [7:0] Ascii0   = 8'h30;
  localparam logic [7:0] Ascii7   = 8'h37;

endpackage

// File: rtl/ascii2nib.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' to a nibble.
module ascii2nib (
  input  logic [7:0] data,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    if (data >= 8'h30 && data <= 8'h39) begin
      nibble = 4'(data - 8'h30);
    end else if (data >= 8'h41 && data <= 8'h46) begin
      nibble = 4'(data - 8'h37);
    end else if (data >= 8'h61 && data <= 8'h66) begin
      nibble = 4'(data - 8'h57);
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "W a h h CR" / "R a CR" byte commands from a UART receiver into RAM
// write/read strobes and latches read data for the 7-segment display.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [2:0] waddr,
  output logic       wen,
  output logic [7:0] wdata,
  output logic [2:0] raddr,
  output logic       ren,
  input  logic [7:0] rdata,
  output logic [7:0] fnd_data,
  output logic       cmd_ok,
  output logic       cmd_err
);

  localparam int unsigned CntW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_t          state;
  logic [2:0]      addr;
  logic [3:0]      hi;
  logic [3:0]      lo;
  logic [CntW-1:0] rd_cnt;

  logic       hex_valid;
  logic [3:0] hex_nib;

  ascii2nib u_ascii2nib (
    .data   (rx_data),
    .valid  (hex_valid),
    .nibble (hex_nib)
  );

  logic       is_cr, is_lf, is_w, is_r, is_addr;
  logic [2:0] addr_dig;
  state_t     bad_state;

  assign is_cr    = (rx_data == AsciiCr);
  assign is_lf    = (rx_data == AsciiLf);
  assign is_w     = (rx_data == AsciiWUp) || (rx_data == AsciiWLo);
  assign is_r     = (rx_data == AsciiRUp) || (rx_data == AsciiRLo);
  assign is_addr  = (rx_data >= Ascii0) && (rx_data <= Ascii7);
  assign addr_dig = 3'(rx_data - Ascii0);
  // An early CR ends the line, so there is nothing left to skip.
  assign bad_state = is_cr ? StIdle : StSkip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      addr     <= '0;
      hi       <= '0;
      lo       <= '0;
      rd_cnt   <= '0;
      waddr    <= '0;
      wen      <= 1'b0;
      wdata    <= '0;
      raddr    <= '0;
      ren      <= 1'b0;
      fnd_data <= '0;
      cmd_ok   <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      wen     <= 1'b0;
      ren     <= 1'b0;
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
      if (state == StRWait) begin
        if (rd_cnt == CntW'(RD_LAT)) begin
          fnd_data <= rdata;
          cmd_ok   <= 1'b1;
          state    <= StIdle;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
        if (rx_done) cmd_err <= 1'b1;
      end else if (rx_done && wen) begin
        // Byte landing in the write strobe cycle is dropped.
        cmd_err <= 1'b1;
      end else if (rx_done) begin
        case (state)
          StIdle: begin
            if (is_w) begin
              state <= StWAddr;
            end else if (is_r) begin
              state <= StRAddr;
            end else if (!(is_cr || is_lf)) begin
              state   <= StSkip;
              cmd_err <= 1'b1;
            end
          end
          StWAddr, StRAddr: begin
            if (is_addr) begin
              addr  <= addr_dig;
              state <= (state == StWAddr) ? StWHi : StRCr;
            end else begin
              state   <= bad_state;
              cmd_err <= 1'b1;
            end
          end
          StWHi: begin
            if (hex_valid) begin
              hi    <= hex_nib;
              state <= StWLo;
            end else begin
              state   <= bad_state;
              cmd_err <= 1'b1;
            end
          end
          StWLo: begin
            if (hex_valid) begin
              lo    <= hex_nib;
              state <= StWCr;
            end else begin
              state   <= bad_state;
              cmd_err <= 1'b1;
            end
          end
          StWCr: begin
            if (is_cr) begin
              wen    <= 1'b1;
              waddr  <= addr;
              wdata  <= {hi, lo};
              cmd_ok <= 1'b1;
              state  <= StIdle;
            end else begin
              state   <= StSkip;
              cmd_err <= 1'b1;
            end
          end
          StRCr: begin
            if (is_cr) begin
              ren    <= 1'b1;
              raddr  <= addr;
              rd_cnt <= '0;
              state  <= StRWait;
            end else begin
              state   <= StSkip;
              cmd_err <= 1'b1;
            end
          end
          StSkip: begin
            if (is_cr) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
